svf_bias_ctrl: RTL
==================

Name: svf_bias_ctrl

Overview:
Digital control stage directly upstream of the analog gm-C state-variable filter macro. It converts the SID filter registers (11-bit cutoff, 4-bit resonance, 2-bit mode) into slew-limited bias DAC codes for the fc and Q bias currents. It also drives the filter's `sel` input, with a mute/switch/settle sequence so mode changes never produce audible clicks. Outputs feed the two bias DACs, the filter `sel` pins and the post-filter mute switch.

Parameters:
FC_W, 8, width of fc bias DAC code
Q_W, 6, width of Q bias DAC code
Q_MIN, 4, minimum q_code (damping floor; prevents self-oscillation)
SLEW_DIV, 2, ticks per 1-LSB slew step of fc_code/q_code (>=1)
MUTE_TICKS, 16, ticks mute is held before sel changes
SETTLE_TICKS, 32, ticks after sel change (or reset) before mute releases

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tick  in  1  sample-rate strobe, one clk wide; all timing counts ticks
fc_reg  in  11  SID cutoff register
res_reg  in  4  SID resonance register
mode_reg  in  2  requested mode: 00=LP, 01=BP, 10=HP, 11=bypass
fc_code  out  FC_W  fc bias DAC code (integrator OTAs)
q_code  out  Q_W  Q bias DAC code (damping OTA)
sel  out  2  filter macro mode select
mute  out  1  1 = silence filter output path
busy  out  1  1 while the mode FSM is not IDLE

Behaviour:
- Reset (async, rst_n=0) values:
  - fc_code=0, q_code=2^Q_W-1, sel=00, mute=1, busy=1.
  - FSM enters SETTLE with counter=SETTLE_TICKS; slew divider=0.
- Targets, combinational from the inputs:
  - fc_tgt = fc_reg[10 -: FC_W], i.e. top bits, truncated.
  - q_raw = ~res_reg replicated MSB-first to Q_W bits. For Q_W=6: {~res, ~res[3:2]}, so res=0 gives 63 and res=15 gives 0.
  - q_tgt = max(q_raw, Q_MIN).
- Slew:
  - Divider counts ticks 0..SLEW_DIV-1. On a tick with divider==SLEW_DIV-1 the divider wraps to 0 and a step is issued.
  - On a step, fc_code moves 1 LSB toward fc_tgt and q_code moves 1 LSB toward q_tgt. A code equal to its target holds.
  - fc and q slew independently; no overshoot; no wrap-around at 0 or max.
  - Targets are re-evaluated every step, so a target change mid-ramp reverses or extends the ramp.
- Mode FSM (counter decrements only on tick):
  - IDLE: mute=0, busy=0. If mode_reg!=sel, go to MUTE with cnt=MUTE_TICKS and set mute=1 in the same clk edge.
  - MUTE: on a tick with cnt==1, go to SWITCH.
  - SWITCH: lasts one clk. sel<=mode_reg (value sampled at this edge). Go to SETTLE with cnt=SETTLE_TICKS.
  - SETTLE: on a tick with cnt==1: if mode_reg!=sel go to SWITCH (mute stays 1); else go to IDLE and mute<=0.
  - mode_reg changes during MUTE or SETTLE are absorbed: only the value present at SWITCH is applied. No extra MUTE phase is added.
- mute is registered. busy = (state!=IDLE).
- Slew runs in all FSM states, including while muted.
- Reset mid-ramp or mid-sequence returns immediately to the reset values above; no partial state survives.
- tick stuck at 0 freezes all codes and the FSM. Registers may still be written; targets are applied once ticks resume.

Decomposition:
- Shared package svf_pkg holds:
  - mode enum (MODE_LP=2'b00, MODE_BP=2'b01, MODE_HP=2'b10, MODE_BYP=2'b11);
  - FSM state enum (S_IDLE, S_MUTE, S_SWITCH, S_SETTLE);
  - default widths FC_W/Q_W.
- One sub-module is natural: svf_slew, instantiated twice (FC_W and Q_W). It is a parameterised up/down 1-LSB tracker with step-enable input and reset value. Divider and FSM stay in the top.

Test Plan:
- Reset release, tick every 4 clk, mode_reg=00 -> mute=1, busy=1 for exactly 32 ticks, then mute=0, busy=0; sel stays 00 throughout.
- fc_reg=11'h7FF from fc_code=0, SLEW_DIV=2 -> fc_code increments by 1 every 2 ticks, reaches 255 after 510 ticks, then holds; never exceeds 255.
- res_reg 0->15 -> q_tgt goes 63->Q_MIN=4 (not 0); q_code ramps down by 1 per step, stops at 4.
- In IDLE, mode_reg 00->10 -> mute=1 next clk; after 16 ticks sel=10; mute=0 after 32 further ticks.
- Mode sequence 00->01->11, with 01 applied during MUTE and 11 during SETTLE -> sel goes 01 at SWITCH; at SETTLE end it re-enters SWITCH, sel=11, waits 32 more ticks; mute stays 1 continuously until release.
- rst_n pulsed low mid-ramp (fc_code=100) and mid-SETTLE -> all outputs take reset values asynchronously; after release the power-on SETTLE of 32 ticks repeats.

Source files
------------

// File: rtl/svf_pkg.sv
// rtl/svf_pkg.sv - shared mode/state types and default code widths for the SVF bias controller
package svf_pkg;

  localparam int FC_W_DEF = 8;
  localparam int Q_W_DEF  = 6;

  typedef enum logic [1:0] {
    MODE_LP  = 2'b00,
    MODE_BP  = 2'b01,
    MODE_HP  = 2'b10,
    MODE_BYP = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MUTE   = 2'd1,
    S_SWITCH = 2'd2,
    S_SETTLE = 2'd3
  } state_e;

endpackage

// File: rtl/svf_slew.sv
// rtl/svf_slew.sv - 1-LSB-per-step up/down tracker driving a bias DAC code toward its target
module svf_slew #(
  parameter int           W       = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  input  logic [W-1:0] tgt,
  output logic [W-1:0] code
);

  // Single-LSB moves only, so the code can never overshoot or wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code <= RST_VAL;
    end else if (step) begin
      if (code < tgt) begin
        code <= code + 1'b1;
      end else if (code > tgt) begin
        code <= code - 1'b1;
      end
    end
  end

endmodule

// File: rtl/svf_bias_ctrl.sv
// rtl/svf_bias_ctrl.sv - SID filter registers to slew-limited fc/Q bias codes plus click-free mode switching
module svf_bias_ctrl
  import svf_pkg::*;
#(
  parameter int FC_W         = FC_W_DEF,
  parameter int Q_W          = Q_W_DEF,
  parameter int Q_MIN        = 4,
  parameter int SLEW_DIV     = 2,
  parameter int MUTE_TICKS   = 16,
  parameter int SETTLE_TICKS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic [10:0]     fc_reg,
  input  logic [3:0]      res_reg,
  input  logic [1:0]      mode_reg,
  output logic [FC_W-1:0] fc_code,
  output logic [Q_W-1:0]  q_code,
  output logic [1:0]      sel,
  output logic            mute,
  output logic            busy
);

  localparam int DIV_W   = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
  localparam int CNT_MAX = (MUTE_TICKS > SETTLE_TICKS) ? MUTE_TICKS : SETTLE_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLEW_DIV - 1);

  logic [FC_W-1:0]  fc_tgt;
  logic [Q_W-1:0]   q_raw;
  logic [Q_W-1:0]   q_tgt;
  logic [DIV_W-1:0] div;
  logic             step;
  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_done;

  assign fc_tgt = fc_reg[10 -: FC_W];

  if (FC_W < 11) begin : g_fc_trunc
    logic unused_fc_lsbs;
    assign unused_fc_lsbs = ^fc_reg[10-FC_W:0];
  end

  // Inverted resonance repeated MSB-first: more resonance means less damping current.
  always_comb begin
    q_raw = '0;
    for (int i = 0; i < Q_W; i++) begin
      q_raw[Q_W-1-i] = ~res_reg[3 - (i % 4)];
    end
    q_tgt = (q_raw < Q_W'(Q_MIN)) ? Q_W'(Q_MIN) : q_raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (tick) begin
      div <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

  assign step = tick && (div == DIV_LAST);

  svf_slew #(.W(FC_W), .RST_VAL('0)) u_fc_slew (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (step),
    .tgt   (fc_tgt),
    .code  (fc_code)
  );

  svf_slew #(.W(Q_W), .RST_VAL({Q_W{1'b1}})) u_q_slew (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (step),
    .tgt   (q_tgt),
    .code  (q_code)
  );

  assign cnt_done = tick && (cnt == CNT_W'(1));

  // Power-on goes straight to SETTLE so the analog core stabilises before unmute.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_SETTLE;
      cnt   <= CNT_W'(SETTLE_TICKS);
      sel   <= MODE_LP;
      mute  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (mode_reg != sel) begin
            state <= S_MUTE;
            cnt   <= CNT_W'(MUTE_TICKS);
            mute  <= 1'b1;
          end
        end
        S_MUTE: begin
          if (cnt_done) begin
            state <= S_SWITCH;
          end else if (tick) begin
            cnt <= cnt - 1'b1;
          end
        end
        S_SWITCH: begin
          sel   <= mode_reg;
          state <= S_SETTLE;
          cnt   <= CNT_W'(SETTLE_TICKS);
        end
        S_SETTLE: begin
          if (cnt_done) begin
            if (mode_reg != sel) begin
              state <= S_SWITCH;
            end else begin
              state <= S_IDLE;
              mute  <= 1'b0;
            end
          end else if (tick) begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);

endmodule
